// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: memory-op encodings, FSM states and writeback selects shared across the pipeline
package mem_stage_pkg;

    typedef enum logic [4:0] {
        MEM_NONE = 5'd0,
        MEM_SB   = 5'd1,
        MEM_SH   = 5'd2,
        MEM_SW   = 5'd3,
        MEM_LB   = 5'd4,
        MEM_LBU  = 5'd5,
        MEM_LH   = 5'd6,
        MEM_LHU  = 5'd7,
        MEM_LW   = 5'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] WB_ALU = 4'd0;
    localparam logic [3:0] WB_MEM = 4'd1;
    localparam logic [3:0] WB_PC4 = 4'd2;
    localparam logic [3:0] WB_CSR = 4'd3;

    function automatic logic is_mem_op(input logic [4:0] op);
        return op >= MEM_SB && op <= MEM_LW;
    endfunction

    function automatic logic is_store_op(input logic [4:0] op);
        return op == MEM_SB || op == MEM_SH || op == MEM_SW;
    endfunction

    // halfwords need bit 0 clear, words need both low bits clear; bytes never fault
    function automatic logic is_misaligned(input logic [4:0] op, input logic [1:0] lo);
        return ((op == MEM_SH || op == MEM_LH || op == MEM_LHU) && lo[0]) ||
               ((op == MEM_SW || op == MEM_LW) && lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: store lane shift/mask and load lane extract/extend, purely combinational
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      op,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wsrc,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      wmask,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [7:0]  b;
    logic [15:0] h;

    // pick the addressed lanes, then build masks and extended load data
    always_comb begin
        b     = rword[{addr_lo, 3'b000} +: 8];
        h     = rword[{addr_lo[1], 4'b0000} +: 16];
        wmask = op == MEM_SB ? 4'b0001 << addr_lo :
                op == MEM_SH ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
                op == MEM_SW ? 4'b1111 : 4'b0000;
        wdata = op == MEM_SB ? {4{wsrc[7:0]}} :
                op == MEM_SH ? {2{wsrc[15:0]}} : wsrc;
        rdata = op == MEM_LB  ? {{(XLEN-8){b[7]}}, b} :
                op == MEM_LBU ? {{(XLEN-8){1'b0}}, b} :
                op == MEM_LH  ? {{(XLEN-16){h[15]}}, h} :
                op == MEM_LHU ? {{(XLEN-16){1'b0}}, h} :
                op == MEM_LW  ? rword : '0;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage with valid/ready requests, load alignment and upstream stall
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_reg_pc,
    input  logic [XLEN-1:0]   in_alu_out,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [4:0]        in_mem_op,
    input  logic              in_rf_wen,
    input  logic [3:0]        in_wb_sel,
    input  logic [4:0]        in_wb_addr,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_wen,
    output logic [3:0]        dmem_wmask,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              stall,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_reg_pc,
    output logic [XLEN-1:0]   out_alu_out,
    output logic [XLEN-1:0]   out_load_data,
    output logic              out_rf_wen,
    output logic [3:0]        out_wb_sel,
    output logic [4:0]        out_wb_addr,
    output logic              out_misaligned
);

    state_e          state;
    logic [XLEN-1:0] c_pc, c_alu, c_rs2;
    logic [4:0]      c_op, c_wb_addr;
    logic            c_rf_wen;
    logic [3:0]      c_wb_sel;

    logic            idle, mis, go, bypass, store, accept, resp_done, retire;
    logic [XLEN-1:0] sel_pc, sel_alu, sel_rs2, load_data;
    logic [4:0]      sel_op, sel_wb_addr;
    logic            sel_rf_wen;
    logic [3:0]      sel_wb_sel;

    // in IDLE the live bundle drives everything; otherwise the captured copy does
    assign idle        = state == IDLE;
    assign sel_pc      = idle ? in_reg_pc   : c_pc;
    assign sel_alu     = idle ? in_alu_out  : c_alu;
    assign sel_rs2     = idle ? in_rs2_data : c_rs2;
    assign sel_op      = idle ? in_mem_op   : c_op;
    assign sel_rf_wen  = idle ? in_rf_wen   : c_rf_wen;
    assign sel_wb_sel  = idle ? in_wb_sel   : c_wb_sel;
    assign sel_wb_addr = idle ? in_wb_addr  : c_wb_addr;

    assign mis       = is_misaligned(in_mem_op, in_alu_out[1:0]);
    assign go        = idle && in_valid && is_mem_op(in_mem_op) && !mis;
    assign bypass    = idle && in_valid && !go;
    assign store     = is_store_op(sel_op);
    assign accept    = dmem_req_valid && dmem_req_ready;
    assign resp_done = state == RESP && dmem_rvalid;
    assign retire    = bypass || (accept && store) || resp_done;

    assign dmem_req_valid = go || state == REQ;
    assign dmem_addr      = {sel_alu[ADDR_W-1:2], 2'b00};
    assign dmem_wen       = dmem_req_valid && store;
    assign stall          = !idle || (go && !dmem_req_ready);

    mem_align #(.XLEN(XLEN)) u_align (
        .op      (sel_op),
        .addr_lo (sel_alu[1:0]),
        .wsrc    (sel_rs2),
        .rword   (dmem_rdata),
        .wmask   (dmem_wmask),
        .wdata   (dmem_wdata),
        .rdata   (load_data)
    );

    // access FSM, bundle capture and registered writeback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            c_pc           <= '0;
            c_alu          <= '0;
            c_rs2          <= '0;
            c_op           <= '0;
            c_rf_wen       <= 1'b0;
            c_wb_sel       <= '0;
            c_wb_addr      <= '0;
            out_valid      <= 1'b0;
            out_reg_pc     <= '0;
            out_alu_out    <= '0;
            out_load_data  <= '0;
            out_rf_wen     <= 1'b0;
            out_wb_sel     <= '0;
            out_wb_addr    <= '0;
            out_misaligned <= 1'b0;
        end else begin
            if (idle) begin
                c_pc      <= in_reg_pc;
                c_alu     <= in_alu_out;
                c_rs2     <= in_rs2_data;
                c_op      <= in_mem_op;
                c_rf_wen  <= in_rf_wen;
                c_wb_sel  <= in_wb_sel;
                c_wb_addr <= in_wb_addr;
            end
            out_valid      <= retire;
            out_misaligned <= bypass && mis;
            if (retire) begin
                out_reg_pc    <= sel_pc;
                out_alu_out   <= sel_alu;
                out_wb_sel    <= sel_wb_sel;
                out_wb_addr   <= sel_wb_addr;
                out_rf_wen    <= sel_rf_wen && !(bypass && mis);
                out_load_data <= resp_done ? load_data : '0;
            end
            state <= accept ? (store ? IDLE : RESP) :
                     go ? REQ :
                     resp_done ? IDLE : state;
        end
    end

endmodule
